// File: rtl/alu_pkg.sv
// Shared definitions for alu_arbiter and its ALU: opcodes, FSM state encoding
// and the opcode legality check.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= ALU_ADD) && (op <= ALU_XOR);
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational ALU shared by both requesters; undefined opcodes give 0.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0] i_op,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  output logic [WIDTH-1:0]    o_y
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves o_y unassigned,
    // which would otherwise infer a latch.
    o_y = '0;
    case (i_op)
      OP_WIDTH'(ALU_ADD): o_y = i_a + i_b;
      OP_WIDTH'(ALU_SUB): o_y = i_a - i_b;
      OP_WIDTH'(ALU_AND): o_y = i_a & i_b;
      OP_WIDTH'(ALU_OR):  o_y = i_a | i_b;
      OP_WIDTH'(ALU_XOR): o_y = i_a ^ i_b;
      default:            o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready front end for a single shared ALU with a registered,
// tagged response. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OP_WIDTH-1:0] req0_op,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OP_WIDTH-1:0] req1_op,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_zero,
  output logic                rsp_err
);

  state_t              r_state;
  logic [OP_WIDTH-1:0] r_op;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_id;
  logic [WIDTH-1:0]    r_rsp_data;
  logic                r_rsp_id;
  logic                r_rsp_zero;
  logic                r_rsp_err;

  logic                w_grant_id;
  logic                w_idle;
  logic                w_xfer;
  logic                w_legal;
  logic [WIDTH-1:0]    w_alu_y;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant_id = !req0_valid;
`else
  logic r_last_grant;

  // Contention goes to whoever did not win the previous transfer.
  assign w_grant_id = (req0_valid && req1_valid) ? !r_last_grant : !req0_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      r_last_grant <= w_grant_id;
    end
  end
`endif

  assign w_idle     = !rst && (r_state == ST_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_grant_id;
  assign req1_ready = w_idle && req1_valid && w_grant_id;
  assign w_xfer     = req0_ready || req1_ready;

  // Upper opcode bits beyond the defined 3-bit codes must be zero to be legal.
  assign w_legal = is_legal_op(r_op[2:0]) && (r_op == OP_WIDTH'(r_op[2:0]));

  alu #(
    .WIDTH    (WIDTH),
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= ST_EXEC;
            r_id    <= w_grant_id;
            r_op    <= w_grant_id ? req1_op : req0_op;
            r_a     <= w_grant_id ? req1_a  : req0_a;
            r_b     <= w_grant_id ? req1_b  : req0_b;
          end
        end
        ST_EXEC: begin
          r_rsp_data <= w_alu_y;
          r_rsp_zero <= (w_alu_y == '0);
          r_rsp_err  <= !w_legal;
          r_rsp_id   <= r_id;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized phase,
// all checked against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 = accepting, 1 = evaluating, 2 = response held.
  int          m_phase;
  bit          m_last;
  bit          m_id;
  bit          m_err;
  logic [31:0] m_data;
  bit          x0, x1;

  logic [31:0] s_data;
  bit          s_id, s_zero, s_err;
  int          s_lat;

  alu_arbiter #(.WIDTH(32), .OP_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit grant_of(input bit v0, input bit v1, input bit last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return !last;
    return v0 ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic m_reset();
    m_phase = 0;
    m_last  = 1'b1;
  endtask

  // Called at a falling edge with inputs already set; checks, advances the model
  // across the next rising edge, and returns at the following falling edge.
  task automatic cycle();
    bit g, e0, e1;
    #1;
    g  = grant_of(req0_valid, req1_valid, m_last);
    e0 = !rst && m_phase == 0 && req0_valid && !g;
    e1 = !rst && m_phase == 0 && req1_valid && g;
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("rsp_valid", rsp_valid, m_phase == 2);
    if (m_phase == 2) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_data", rsp_data, m_data);
      check("rsp_zero", rsp_zero, m_data == 0);
      check("rsp_err", rsp_err, m_err);
    end
    x0 = e0;
    x1 = e1;
    if (rst) m_reset();
    else begin
      case (m_phase)
        0: if (e0 || e1) begin
          m_phase = 1;
          m_id    = g;
          m_last  = g;
          m_data  = g ? ref_result(req1_op, req1_a, req1_b) : ref_result(req0_op, req0_a, req0_b);
          m_err   = g ? !(req1_op inside {[3'd1:3'd5]}) : !(req0_op inside {[3'd1:3'd5]});
        end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready  = 1;
    repeat (4) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {rsp_valid, rsp_id, rsp_zero, rsp_err, req0_ready, req1_ready}, 6'b0);
    check({tag, "_data"}, rsp_data, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check_all_zero("reset");
    m_reset();
    cycle();
    cycle();
    rst = 0;
  endtask

  // Issue one request on one requester, wait for its response, capture it.
  task automatic single(input bit id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit rr);
    bit got;
    rsp_ready = rr;
    if (id) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req0_valid = 0;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req1_valid = 0;
    end
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      got = id ? req1_ready : req0_ready;
      cycle();
    end
    check("grant_wait", got, 1'b1);
    req0_valid = 0;
    req1_valid = 0;
    s_lat = 1;
    for (int i = 0; i < 8 && !rsp_valid; i++) begin
      cycle();
      s_lat++;
    end
    check("rsp_wait", rsp_valid, 1'b1);
    s_data = rsp_data;
    s_id   = rsp_id;
    s_zero = rsp_zero;
    s_err  = rsp_err;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit exp_id, got_any;
    int k;
    logic [31:0] hold;

    rst = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 0;
    m_reset();
    @(negedge clk);
    do_reset();

    // ADD 5+3 on requester 0
    req0_valid = 1; req0_op = 3'b001; req0_a = 32'd5; req0_b = 32'd3;
    #1;
    check("t1_ready0", req0_ready, 1'b1);
    single(0, 3'b001, 32'd5, 32'd3, 1);
    check("t1_latency", s_lat, 2);
    check("t1_fields", {s_id, s_zero, s_err}, 3'b000);
    check("t1_data", s_data, 32'd8);
    cycle();
    drain();

    // Both requesters continuously valid
    do_reset();
    rsp_ready = 1;
    req0_valid = 1; req0_op = 3'b010; req0_a = 32'd10; req0_b = 32'd10;
    req1_valid = 1; req1_op = 3'b101; req1_a = 32'hFFFF_0000; req1_b = 32'h0000_FFFF;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_id = 1'b0;
`else
        exp_id = k[0];
`endif
        check("alt_grant", req1_ready, exp_id);
        k++;
      end
      cycle();
    end
    check("alt_count", k, 4);
    drain();

    // Undefined opcode on requester 1
    single(1, 3'b111, 32'd1, 32'd1, 1);
    check("bad_op", {s_id, s_zero, s_err}, 3'b111);
    check("bad_op_data", s_data, 32'h0);
    cycle();
    drain();

    // Backpressure for 10 cycles with requester 1 waiting
    single(0, 3'b100, 32'h00F0_0000, 32'h0000_000F, 0);
    hold = s_data;
    req1_valid = 1; req1_op = 3'b011; req1_a = 32'hF0F0_F0F0; req1_b = 32'hFF00_FF00;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_data", rsp_data, hold);
      check("bp_ready", {req0_ready, req1_ready}, 2'b00);
      cycle();
    end
    rsp_ready = 1;
    cycle();
    check("bp_release", rsp_valid, 1'b0);
    got_any = 0;
    for (int i = 0; i < 4 && !got_any; i++) begin
      cycle();
      got_any = x1;
    end
    req1_valid = 0;
    drain();

    // Wrap-around corners
    single(0, 3'b001, 32'hFFFF_FFFF, 32'd1, 1);
    check("add_wrap", {s_data, s_zero, s_err}, {32'h0, 1'b1, 1'b0});
    cycle();
    single(1, 3'b010, 32'd0, 32'd1, 1);
    check("sub_wrap", s_data, 32'hFFFF_FFFF);
    cycle();
    drain();

    // Asynchronous reset while evaluating
    req0_valid = 1; req0_op = 3'b001; req0_a = 32'd7; req0_b = 32'd9;
    cycle();
    req0_valid = 0;
    #2;
    rst = 1;
    #1;
    check_all_zero("rst_exec");
    m_reset();
    @(negedge clk);
    cycle();
    rst = 0;
    single(1, 3'b011, 32'hFF, 32'h0F, 1);
    check("post_rst_id", s_id, 1'b1);
    check("post_rst_data", s_data, 32'h0F);
    cycle();
    drain();
    do_reset();
    req0_valid = 1; req0_op = 3'b001; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1; req1_op = 3'b001; req1_a = 32'd3; req1_b = 32'd4;
    #1;
    check("first_win", {req0_ready, req1_ready}, 2'b10);
    cycle();
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (x0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 3'($urandom_range(0, 7)); req0_a = rand_word(); req0_b = rand_word();
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 0;
      end
      if (x1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 3'($urandom_range(0, 7)); req1_a = rand_word(); req1_b = rand_word();
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
